// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority arbiter.
package arb_pkg;

    // Widest request vector the helpers handle; narrower vectors are zero-extended.
    localparam int MAX_N    = 32;
    localparam int MAX_IDXW = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Encode a one-hot (or zero) vector into its bit index; zero maps to 0.
    function automatic logic [MAX_IDXW-1:0] onehot_to_idx(input logic [MAX_N-1:0] onehot);
        logic [MAX_IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (onehot[i]) idx = idx | MAX_IDXW'(i);
        end
        return idx;
    endfunction

    // First unmasked requester found scanning upward from ptr, wrapping at n-1.
    function automatic logic [MAX_IDXW-1:0] rotate_pick(
        input logic [MAX_N-1:0]    request,
        input logic [MAX_IDXW-1:0] ptr,
        input logic [MAX_N-1:0]    mask,
        input int                  n
    );
        logic [MAX_N-1:0]    cand;
        logic [MAX_IDXW-1:0] pick;
        logic                hit;
        int                  pos;
        cand = request & ~mask;
        pick = '0;
        hit  = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && !hit) begin
                pos = int'(ptr) + i;
                if (pos >= n) pos = pos - n;
                if (cand[MAX_IDXW'(pos)]) begin
                    pick = MAX_IDXW'(pos);
                    hit  = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational masked rotating-priority picker. In fixed mode the scan
// starts at index 0, so the lowest unmasked requester wins.
module arb_pick
    import arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     exclude_mask,
    input  logic             fixed,
    output logic [IDX_W-1:0] winner_idx,
    output logic             found
);

    logic [IDX_W-1:0] w_start;

    // Choose the scan start and pick the first eligible requester from it.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no path leaves it unassigned and no latch is inferred.
        w_start    = '0;
        winner_idx = '0;
        found      = 1'b0;
        if (!fixed) w_start = ptr;
        winner_idx = IDX_W'(rotate_pick(MAX_N'(request), MAX_IDXW'(w_start),
                                        MAX_N'(exclude_mask), N));
        found      = |(request & ~exclude_mask);
    end

endmodule

// File: rtl/arbiter_rr.sv
// N-channel arbiter: round-robin or fixed priority, grant locks while the
// owner keeps requesting, optional max-hold limit forces rotation.
// Grant, index and valid are all registered (no request-to-grant comb path).
module arbiter_rr
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 4,
    localparam int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     request,
    input  logic             prio_mode,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    localparam int               HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [N-1:0]     ONE       = N'(1);

    state_t           r_state;
    logic [N-1:0]     r_grant;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_valid;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [HC_W-1:0]  r_hold_cnt;

    logic [N-1:0]     w_exclude;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_found;
    logic [N-1:0]     w_win_onehot;
    logic [IDX_W-1:0] w_next_ptr;
    logic             w_owner_req;
    logic             w_others;
    logic             w_limit;

    // The current owner is never a candidate while granted: if it still
    // requests it is either kept or being forced off; if it dropped, its bit is 0.
    assign w_exclude    = (r_state == GRANT) ? r_grant : '0;
    assign w_owner_req  = |(request & r_grant);
    assign w_others     = |(request & ~r_grant);
    assign w_limit      = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_win_onehot = ONE << w_win_idx;
    assign w_next_ptr   = (w_win_idx == IDX_W'(N - 1)) ? '0 : w_win_idx + IDX_W'(1);

    arb_pick #(.N(N)) u_pick (
        .request      (request),
        .ptr          (r_rr_ptr),
        .exclude_mask (w_exclude),
        .fixed        (prio_mode),
        .winner_idx   (w_win_idx),
        .found        (w_found)
    );

    // Arbitration FSM: grant, hold, forced rotation, hand-over and idle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values, matching hardware.
        if (!rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_valid     <= 1'b0;
            r_rr_ptr    <= '0;
            r_hold_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= GRANT;
                        r_grant     <= w_win_onehot;
                        r_grant_idx <= w_win_idx;
                        r_valid     <= 1'b1;
                        r_rr_ptr    <= w_next_ptr;
                        r_hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (w_owner_req && (!w_others || !w_limit)) begin
                        // Keep the owner; counter saturates at the limit.
                        if (MAX_HOLD != 0 && r_hold_cnt != HOLD_LAST)
                            r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    end else if (w_others) begin
                        // Owner dropped, or hold limit reached: hand over directly.
                        r_grant     <= w_win_onehot;
                        r_grant_idx <= w_win_idx;
                        r_valid     <= 1'b1;
                        r_rr_ptr    <= w_next_ptr;
                        r_hold_cnt  <= '0;
                    end else begin
                        r_state     <= IDLE;
                        r_grant     <= '0;
                        r_grant_idx <= '0;
                        r_valid     <= 1'b0;
                        r_hold_cnt  <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_valid;

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr (N=4, MAX_HOLD=4): a behavioural model pushes the
// expected outputs of each edge to a scoreboard queue; each scenario pops
// and compares after the edge, plus fixed expectations from the test plan.
module tb_arbiter_rr;

    localparam int N    = 4;
    localparam int MAXH = 4;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] request;
    logic       prio_mode;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    int m_owner;
    int m_ptr;
    int m_hold;

    arbiter_rr #(.N(N), .MAX_HOLD(MAXH)) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .prio_mode   (prio_mode),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1);
    end

    function automatic int m_pick(input logic [3:0] req, input int ptr, input int excl,
                                  input logic fixed);
        int start;
        int c;
        start = fixed ? 0 : ptr;
        for (int k = 0; k < N; k++) begin
            c = (start + k) % N;
            if (req[2'(c)] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        sb.delete();
    endtask

    // Advance the model for the coming edge and queue what the DUT should show.
    task automatic model_edge();
        int   w;
        logic own;
        logic others;
        exp_t x;
        if (m_owner < 0) begin
            w = m_pick(request, m_ptr, -1, prio_mode);
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 0;
                m_ptr   = (w + 1) % N;
            end
        end else begin
            own    = request[2'(m_owner)];
            others = (request & ~(4'b0001 << m_owner)) != 4'b0000;
            if (own && (!others || m_hold < MAXH - 1)) begin
                if (m_hold < MAXH - 1) m_hold++;
            end else if (others) begin
                w       = m_pick(request, m_ptr, m_owner, prio_mode);
                m_owner = w;
                m_hold  = 0;
                m_ptr   = (w + 1) % N;
            end else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end
        x.grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        x.idx   = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        x.valid = (m_owner >= 0);
        sb.push_back(x);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #7 rst = 1'b0;
        m_reset();
        #1;
        checks++;
        if ({grant, grant_idx, grant_valid} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset: got %b/%0d/%b want 0000/0/0", grant, grant_idx, grant_valid);
        end
        #4 rst = 1'b1;
        #2 request = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_idx, grant_valid} !== {e.grant, e.idx, e.valid}) begin
                errors++;
                $display("FAIL single_model c%0d: got %b/%0d/%b want %b/%0d/%b",
                         c, grant, grant_idx, grant_valid, e.grant, e.idx, e.valid);
            end
            checks++;
            if ({grant, grant_idx, grant_valid} !== {4'b0001, 2'd0, 1'b1}) begin
                errors++;
                $display("FAIL single_grant c%0d: got %b/%0d/%b want 0001/0/1",
                         c, grant, grant_idx, grant_valid);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        rst = 1'b0;
        m_reset();
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL rot_reset: got %b want 0000", grant);
        end
        #1 rst = 1'b1;
        prio_mode = 1'b0;
        request   = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_idx, grant_valid} !== {e.grant, e.idx, e.valid}) begin
                errors++;
                $display("FAIL rot_model c%0d: got %b/%0d/%b want %b/%0d/%b",
                         c, grant, grant_idx, grant_valid, e.grant, e.idx, e.valid);
            end
            want = 4'b0001 << ((c / 4) % 4);
            checks++;
            if (grant !== want) begin
                errors++;
                $display("FAIL rot_seq c%0d: got %b want %b", c, grant, want);
            end
        end
    endtask

    task automatic test_fixed_drop();
        logic [3:0] want [3];
        want[0] = 4'b0000;
        want[1] = 4'b0010;
        want[2] = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: request = 4'b0000;
                1: begin prio_mode = 1'b1; request = 4'b1010; end
                default: request = 4'b1000;
            endcase
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_idx, grant_valid} !== {e.grant, e.idx, e.valid}) begin
                errors++;
                $display("FAIL fixed_model c%0d: got %b/%0d/%b want %b/%0d/%b",
                         c, grant, grant_idx, grant_valid, e.grant, e.idx, e.valid);
            end
            checks++;
            if (grant !== want[c]) begin
                errors++;
                $display("FAIL fixed_drop c%0d: got %b want %b", c, grant, want[c]);
            end
        end
    endtask

    task automatic test_lone_idle();
        request = 4'b0100;
        for (int c = 0; c < 11; c++) begin
            if (c == 10) request = 4'b0000;
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_idx, grant_valid} !== {e.grant, e.idx, e.valid}) begin
                errors++;
                $display("FAIL lone_model c%0d: got %b/%0d/%b want %b/%0d/%b",
                         c, grant, grant_idx, grant_valid, e.grant, e.idx, e.valid);
            end
            checks++;
            if (c < 10 && {grant, grant_idx, grant_valid} !== {4'b0100, 2'd2, 1'b1}) begin
                errors++;
                $display("FAIL lone_hold c%0d: got %b/%0d/%b want 0100/2/1",
                         c, grant, grant_idx, grant_valid);
            end else if (c == 10 && {grant, grant_valid} !== 5'b00000) begin
                errors++;
                $display("FAIL lone_idle: got %b/%b want 0000/0", grant, grant_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        request   = 4'b0100;
        prio_mode = 1'b0;
        step();
        e = sb.pop_front();
        checks++;
        if (grant !== 4'b0100 || e.grant !== 4'b0100) begin
            errors++;
            $display("FAIL mid_setup: got %b want 0100", grant);
        end
        #2;
        request = 4'b1111;
        rst     = 1'b0;
        m_reset();
        #1;
        checks++;
        if ({grant, grant_idx, grant_valid} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b/%0d/%b want 0000/0/0", grant, grant_idx, grant_valid);
        end
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_idx, grant_valid} !== {e.grant, e.idx, e.valid}) begin
                errors++;
                $display("FAIL mid_model c%0d: got %b/%0d/%b want %b/%0d/%b",
                         c, grant, grant_idx, grant_valid, e.grant, e.idx, e.valid);
            end
            checks++;
            if ({grant, grant_idx, grant_valid} !== {4'b0001, 2'd0, 1'b1}) begin
                errors++;
                $display("FAIL mid_restart c%0d: got %b/%0d/%b want 0001/0/1",
                         c, grant, grant_idx, grant_valid);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        request   = 4'b0000;
        prio_mode = 1'b0;
        m_reset();
        test_reset();
        test_rotation();
        test_fixed_drop();
        test_lone_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
